// File: rtl/four_bit_rca_rcs.sv
// Ripple-carry adder/subtractor slice for the ALU arithmetic leaf.
// WIDTH full-adder cells, carry rippling LSB to MSB, registered outputs.

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ c;
  assign co = (a & b) | (c & p);

endmodule

module four_bit_rca_rcs #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V
);

  logic [WIDTH-1:0] b_mod;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;
  logic             ovf;

  // Subtract is A + ~B + Cin, so each B bit is conditionally inverted.
  assign b_mod    = B ^ {WIDTH{Sub}};
  assign carry[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_fa (
      .a  (A[i]),
      .b  (b_mod[i]),
      .c  (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  // Signed overflow: carry into the MSB differs from carry out of it.
  assign ovf = carry[WIDTH] ^ carry[WIDTH-1];

  // Output register; reset clears results immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S    <= '0;
      Cout <= 1'b0;
      V    <= 1'b0;
    end else begin
      S    <= sum;
      Cout <= carry[WIDTH];
      V    <= ovf;
    end
  end

endmodule

// File: tb/tb_four_bit_rca_rcs.sv
// Self-checking bench for four_bit_rca_rcs.
// Arithmetic reference model, directed, latency, reset and exhaustive tests.

module tb_four_bit_rca_rcs;

  logic       clk;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic       Cin;
  logic       Sub;
  logic [3:0] S;
  logic       Cout;
  logic       V;

  int checks;
  int failures;

  four_bit_rca_rcs #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .Sub  (Sub),
    .S    (S),
    .Cout (Cout),
    .V    (V)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] model(
    input int a, input int b,
    input int cin, input int sub
  );
    int bb, u, sa, sb, ss;
    logic [5:0] r;
    bb = sub ? (15 - b) : b;
    u  = a + bb + cin;
    sa = (a >= 8) ? a - 16 : a;
    sb = (bb >= 8) ? bb - 16 : bb;
    ss = sa + sb + cin;
    r[3:0] = 4'(u % 16);
    r[4]   = (u >= 16);
    r[5]   = (ss > 7) || (ss < -8);
    return r;
  endfunction

  task automatic check(
    input string tag,
    input logic [5:0] obs,
    input logic [5:0] exp
  );
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got {V,Cout,S}=%b expected %b",
               tag, obs, exp);
    end
  endtask

  task automatic drive(
    input int a, input int b,
    input int cin, input int sub
  );
    @(negedge clk);
    A   = 4'(a);
    B   = 4'(b);
    Cin = 1'(cin);
    Sub = 1'(sub);
  endtask

  task automatic run(
    input string tag,
    input int a, input int b,
    input int cin, input int sub
  );
    drive(a, b, cin, sub);
    @(posedge clk);
    #1;
    check(tag, {V, Cout, S}, model(a, b, cin, sub));
  endtask

  task automatic run_lit(
    input string tag,
    input int a, input int b,
    input int cin, input int sub,
    input logic [5:0] exp
  );
    drive(a, b, cin, sub);
    @(posedge clk);
    #1;
    check(tag, {V, Cout, S}, exp);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    A = 4'd9; B = 4'd6; Cin = 1'b1; Sub = 1'b0;
    #2;
    check("reset_async", {V, Cout, S}, 6'b0);
    @(posedge clk);
    #1;
    check("reset_held", {V, Cout, S}, 6'b0);
    @(negedge clk);
    rst = 1'b0;

    run_lit("add_zero",    0,  0, 0, 0, 6'b0_0_0000);
    run_lit("add_zero_ci", 0,  0, 1, 0, 6'b0_0_0001);
    run_lit("add_ovf",     5,  3, 1, 0, 6'b1_0_1001);
    run_lit("add_9_6",     9,  6, 0, 0, 6'b0_0_1111);
    run_lit("add_wrap",   15,  1, 0, 0, 6'b0_1_0000);
    run_lit("add_f_f",    15, 15, 0, 0, 6'b0_1_1110);
    run_lit("sub_nobor",   5,  3, 1, 1, 6'b0_1_0010);
    run_lit("sub_borrow",  3,  5, 1, 1, 6'b0_0_1110);
    run_lit("sub_ci0",     5,  3, 0, 1, 6'b0_1_0001);
    run_lit("sub_ovf",     8,  1, 1, 1, 6'b1_1_0111);

    drive(7, 2, 0, 0);
    @(posedge clk);
    #1;
    check("lat_first", {V, Cout, S}, model(7, 2, 0, 0));
    drive(12, 9, 1, 1);
    #1;
    check("lat_hold", {V, Cout, S}, model(7, 2, 0, 0));
    @(posedge clk);
    #1;
    check("lat_next", {V, Cout, S}, model(12, 9, 1, 1));
    drive(6, 6, 1, 0);
    @(posedge clk);
    #1;
    check("lat_third", {V, Cout, S}, model(6, 6, 1, 0));

    drive(15, 15, 1, 0);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid", {V, Cout, S}, 6'b0);
    @(posedge clk);
    #1;
    check("rst_discard", {V, Cout, S}, 6'b0);
    @(negedge clk);
    rst = 1'b0;
    run("rst_release", 15, 15, 1, 0);

    for (int i = 0; i < 1024; i++) begin
      run("exhaustive", i & 15, (i >> 4) & 15,
          (i >> 8) & 1, (i >> 9) & 1);
    end

    for (int i = 0; i < 200; i++) begin
      run("random", int'($urandom_range(15)),
          int'($urandom_range(15)),
          int'($urandom_range(1)),
          int'($urandom_range(1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
